// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and types for the register scoreboard.
// Covers register index width, architectural register count and counter types.
package riscv_pkg;

    localparam int RISCV_INSTR_RS_WIDTH = 5;
    localparam int NUM_ARCH_REGS        = 2 ** RISCV_INSTR_RS_WIDTH;
    localparam int SB_CNT_WIDTH         = 2;
    localparam int SB_TOTAL_WIDTH       = 7;

    typedef logic [RISCV_INSTR_RS_WIDTH-1:0] reg_idx_t;
    typedef logic [SB_CNT_WIDTH-1:0]         sb_cnt_t;
    typedef logic [SB_TOTAL_WIDTH-1:0]       sb_total_t;

    localparam sb_cnt_t SB_CNT_MAX  = {SB_CNT_WIDTH{1'b1}};
    localparam sb_cnt_t SB_CNT_ZERO = {SB_CNT_WIDTH{1'b0}};

endpackage

// File: rtl/riscv_v_scoreboard_entry.sv
// One per-register outstanding-write counter with registered busy/saturated flags.
// Simultaneous inc and dec cancel; clr has priority over both.
module riscv_v_scoreboard_entry
    import riscv_pkg::*;
#(
    parameter int CNT_WIDTH = SB_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    logic                 busy_r;
    logic                 sat_r;

    // Next counter value; saturates at both ends so it can never wrap.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (inc && !dec && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else if (dec && !inc && (cnt_r != CNT_ZERO)) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and flag registers; flags are decoded from the next value so they track cnt_r exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= CNT_ZERO;
            busy_r <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            busy_r <= (cnt_nxt_s != CNT_ZERO);
            sat_r  <= (cnt_nxt_s == CNT_MAX);
        end
    end

    assign busy = busy_r;
    assign sat  = sat_r;

endmodule

// File: rtl/riscv_v_scoreboard.sv
// In-order register scoreboard: tracks outstanding writes per architectural register
// and back-pressures decode on RAW hazards or per-register counter saturation.
module riscv_v_scoreboard
    import riscv_pkg::*;
#(
    parameter int RS_WIDTH    = RISCV_INSTR_RS_WIDTH,
    parameter int NUM_REGS    = 2 ** RS_WIDTH,
    parameter int CNT_WIDTH   = SB_CNT_WIDTH,
    parameter int TOTAL_WIDTH = SB_TOTAL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [RS_WIDTH-1:0]    issue_rs1,
    input  logic [RS_WIDTH-1:0]    issue_rs2,
    input  logic                   issue_rs1_used,
    input  logic                   issue_rs2_used,
    input  logic [RS_WIDTH-1:0]    issue_rd,
    input  logic                   issue_rd_we,
    input  logic                   wb_valid,
    input  logic [RS_WIDTH-1:0]    wb_rd,
    output logic                   stall,
    output logic [NUM_REGS-1:0]    busy_vec,
    output logic [TOTAL_WIDTH-1:0] pending_total,
    output logic                   err_underflow
);

    localparam logic [RS_WIDTH-1:0]    RD_ZERO    = {RS_WIDTH{1'b0}};
    localparam logic [TOTAL_WIDTH-1:0] TOTAL_ZERO = {TOTAL_WIDTH{1'b0}};
    localparam logic [TOTAL_WIDTH-1:0] TOTAL_ONE  = {{(TOTAL_WIDTH-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0]    busy_s;
    logic [NUM_REGS-1:0]    sat_s;
    logic [NUM_REGS-1:1]    inc_s;
    logic [NUM_REGS-1:1]    dec_s;
    logic                   raw1_s;
    logic                   raw2_s;
    logic                   waw_sat_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   trk_inc_s;
    logic                   wb_nz_s;
    logic                   wb_same_s;
    logic                   wb_eff_s;
    logic                   underflow_s;
    logic [TOTAL_WIDTH-1:0] total_r;
    logic [TOTAL_WIDTH-1:0] total_nxt_s;
    logic                   err_r;

    // x0 is hardwired and never tracked.
    assign busy_s[0] = 1'b0;
    assign sat_s[0]  = 1'b0;

    // Hazards look only at registered state; a same-cycle writeback does not unblock issue.
    always_comb begin
        raw1_s      = issue_rs1_used && busy_s[issue_rs1];
        raw2_s      = issue_rs2_used && busy_s[issue_rs2];
        waw_sat_s   = issue_rd_we && sat_s[issue_rd];
        ready_s     = !flush && !raw1_s && !raw2_s && !waw_sat_s;
        accept_s    = issue_valid && ready_s;
        trk_inc_s   = accept_s && issue_rd_we && (issue_rd != RD_ZERO);
        wb_nz_s     = !flush && wb_valid && (wb_rd != RD_ZERO);
        wb_same_s   = trk_inc_s && (issue_rd == wb_rd);
        wb_eff_s    = wb_nz_s && (busy_s[wb_rd] || wb_same_s);
        underflow_s = wb_nz_s && !wb_eff_s;
    end

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        assign inc_s[i] = trk_inc_s && (issue_rd == RS_WIDTH'(i));
        assign dec_s[i] = wb_eff_s && (wb_rd == RS_WIDTH'(i));

        riscv_v_scoreboard_entry #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (flush),
            .inc   (inc_s[i]),
            .dec   (dec_s[i]),
            .busy  (busy_s[i]),
            .sat   (sat_s[i])
        );
    end

    // Running total of outstanding writes; a paired accept and writeback leave it unchanged.
    always_comb begin
        total_nxt_s = total_r;
        if (flush) begin
            total_nxt_s = TOTAL_ZERO;
        end else if (trk_inc_s && !wb_eff_s) begin
            total_nxt_s = total_r + TOTAL_ONE;
        end else if (wb_eff_s && !trk_inc_s && (total_r != TOTAL_ZERO)) begin
            total_nxt_s = total_r - TOTAL_ONE;
        end else begin
            total_nxt_s = total_r;
        end
    end

    // Total counter and sticky underflow flag; only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_r <= TOTAL_ZERO;
            err_r   <= 1'b0;
        end else begin
            total_r <= total_nxt_s;
            err_r   <= err_r | underflow_s;
        end
    end

    assign issue_ready   = ready_s;
    assign stall         = issue_valid && !ready_s;
    assign busy_vec      = busy_s;
    assign pending_total = total_r;
    assign err_underflow = err_r;

endmodule

// File: tb/tb_riscv_v_scoreboard.sv
// Directed self-checking bench for riscv_v_scoreboard.
module tb_riscv_v_scoreboard;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    reg_idx_t    issue_rs1 = 5'd0;
    reg_idx_t    issue_rs2 = 5'd0;
    logic        issue_rs1_used = 1'b0;
    logic        issue_rs2_used = 1'b0;
    reg_idx_t    issue_rd = 5'd0;
    logic        issue_rd_we = 1'b0;
    logic        wb_valid = 1'b0;
    reg_idx_t    wb_rd = 5'd0;
    logic        stall;
    logic [31:0] busy_vec;
    sb_total_t   pending_total;
    logic        err_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    riscv_v_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_we    (issue_rd_we),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .stall          (stall),
        .busy_vec       (busy_vec),
        .pending_total  (pending_total),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rs1_used = 1'b0; issue_rs2_used = 1'b0;
        issue_rd_we = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0; wb_rd = 5'd0;
    endtask

    task automatic iss(input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic we);
        issue_valid = 1'b1; issue_rs1 = rs1; issue_rs1_used = u1;
        issue_rs2 = 5'd0; issue_rs2_used = 1'b0; issue_rd = rd; issue_rd_we = we;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1; wb_rd = rd;
    endtask

    initial begin
        idle();
        cyc(); cyc();
        chk("rst_busy", 64'(busy_vec), 64'h0);
        chk("rst_total", 64'(pending_total), 64'h0);
        chk("rst_err", 64'(err_underflow), 64'h0);
        chk("rst_ready", 64'(issue_ready), 64'h1);
        rst_n = 1'b1;
        cyc();

        // RAW on x5
        iss(5'd0, 1'b0, 5'd5, 1'b1); #1;
        chk("raw_first_ready", 64'(issue_ready), 64'h1);
        cyc(); idle();
        chk("raw_busy5", 64'(busy_vec), 64'h20);
        chk("raw_total1", 64'(pending_total), 64'h1);
        iss(5'd5, 1'b1, 5'd6, 1'b1); #1;
        chk("raw_stall", 64'(stall), 64'h1);
        cyc();
        chk("raw_stall_hold", 64'(stall), 64'h1);
        wb(5'd5); #1;
        chk("raw_no_bypass", 64'(stall), 64'h1);
        cyc(); wb_valid = 1'b0; #1;
        chk("raw_ready_after_wb", 64'(issue_ready), 64'h1);
        chk("raw_total_after_wb", 64'(pending_total), 64'h0);
        cyc(); idle();
        chk("raw_busy6", 64'(busy_vec), 64'h40);
        wb(5'd6); cyc(); idle();
        chk("raw_drain", 64'(pending_total), 64'h0);

        // WAW saturation on x7
        iss(5'd0, 1'b0, 5'd7, 1'b1);
        cyc(); cyc(); cyc();
        chk("sat_total3", 64'(pending_total), 64'h3);
        chk("sat_stall", 64'(stall), 64'h1);
        wb(5'd7); #1;
        chk("sat_no_bypass", 64'(issue_ready), 64'h0);
        cyc(); wb_valid = 1'b0; #1;
        chk("sat_total2", 64'(pending_total), 64'h2);
        chk("sat_ready", 64'(issue_ready), 64'h1);
        cyc(); idle();
        chk("sat_total_back3", 64'(pending_total), 64'h3);
        chk("sat_busy7", 64'(busy_vec), 64'h80);
        wb(5'd7); cyc(); cyc(); cyc(); idle();
        chk("sat_drain", 64'(busy_vec), 64'h0);

        // Same-cycle accept + wb on x9 (count 1), then on x10 (count 0)
        iss(5'd0, 1'b0, 5'd9, 1'b1); cyc();
        wb(5'd9); #1;
        chk("same_ready", 64'(issue_ready), 64'h1);
        cyc(); idle();
        chk("same_total", 64'(pending_total), 64'h1);
        chk("same_busy9", 64'(busy_vec), 64'h200);
        chk("same_err", 64'(err_underflow), 64'h0);
        wb(5'd9); cyc(); idle();
        iss(5'd0, 1'b0, 5'd10, 1'b1); wb(5'd10); cyc(); idle();
        chk("same0_busy", 64'(busy_vec), 64'h0);
        chk("same0_total", 64'(pending_total), 64'h0);
        chk("same0_err", 64'(err_underflow), 64'h0);

        // x0 never tracked
        iss(5'd0, 1'b1, 5'd0, 1'b1); issue_rs2_used = 1'b1; wb(5'd0); #1;
        chk("x0_stall", 64'(stall), 64'h0);
        cyc(); idle();
        chk("x0_busy", 64'(busy_vec), 64'h0);
        chk("x0_total", 64'(pending_total), 64'h0);
        chk("x0_err", 64'(err_underflow), 64'h0);

        // Underflow on x12
        wb(5'd12); cyc(); idle();
        chk("uf_err", 64'(err_underflow), 64'h1);
        chk("uf_total", 64'(pending_total), 64'h0);
        cyc();
        chk("uf_sticky", 64'(err_underflow), 64'h1);

        // Flush with simultaneous issue
        iss(5'd0, 1'b0, 5'd3, 1'b1); cyc();
        iss(5'd0, 1'b0, 5'd4, 1'b1); cyc();
        iss(5'd0, 1'b0, 5'd5, 1'b1); cyc();
        chk("fl_total3", 64'(pending_total), 64'h3);
        chk("fl_busy", 64'(busy_vec), 64'h38);
        iss(5'd0, 1'b0, 5'd6, 1'b1); flush = 1'b1; #1;
        chk("fl_ready", 64'(issue_ready), 64'h0);
        chk("fl_stall", 64'(stall), 64'h1);
        cyc(); idle();
        chk("fl_busy0", 64'(busy_vec), 64'h0);
        chk("fl_total0", 64'(pending_total), 64'h0);

        // Async reset mid-operation
        for (int r = 1; r <= 4; r++) begin
            iss(5'd0, 1'b0, 5'(r), 1'b1); cyc();
        end
        idle();
        chk("ar_total4", 64'(pending_total), 64'h4);
        #2 rst_n = 1'b0; #1;
        chk("ar_total", 64'(pending_total), 64'h0);
        chk("ar_busy", 64'(busy_vec), 64'h0);
        chk("ar_err", 64'(err_underflow), 64'h0);
        #2 rst_n = 1'b1;
        iss(5'd0, 1'b0, 5'd1, 1'b1); cyc(); idle();
        chk("ar_busy1", 64'(busy_vec), 64'h2);
        chk("ar_total1", 64'(pending_total), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
